// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and decode helpers for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int unsigned       PC_W        = 16;
   localparam logic [PC_W-1:0]   NOP_INSTR_C = 16'h0800;
   localparam logic [PC_W-1:0]   PC_STEP     = 16'h0002;
   localparam logic [4:0]        HALT_OP     = 5'b00000;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_HOLD   = 3'd2,
      ST_SQUASH = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_e;

   function automatic logic is_halt(input logic [PC_W-1:0] instr);
      return (instr[PC_W-1 -: 5] == HALT_OP);
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that keeps a fetched instruction while decode is stalled.
module fetch_hold_buf
   import fetch_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [PC_W-1:0] data_i,
   output logic [PC_W-1:0] data_o,
   output logic            full_o
);

   logic [PC_W-1:0] data_q;
   logic            full_q;

   // Buffer contents and occupancy; clear wins over load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= NOP_INSTR_C;
         full_q <= 1'b0;
      end else if (clear_i) begin
         data_q <= data_q;
         full_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         full_q <= 1'b1;
      end else begin
         data_q <= data_q;
         full_q <= full_q;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction
// memory and presents {instr, pc+2} to the IF/D register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic [PC_W-1:0] imem_data,
   input  logic            imem_done,
   input  logic            imem_err,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_rd,
   output logic [PC_W-1:0] instr_out,
   output logic [PC_W-1:0] pc_add_2_out,
   output logic            valid,
   output logic            fetch_stall,
   output logic            err,
   output logic            halted
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] tgt_q, tgt_d;
   logic            err_q, err_d;
   logic [PC_W-1:0] pc_inc_s;
   logic            misalign_s;
   logic            buf_load_s;
   logic            buf_clear_s;
   logic [PC_W-1:0] buf_data_s;
   logic            buf_full_s;

   assign pc_inc_s   = pc_q + PC_STEP;
   assign misalign_s = pc_q[0];

   fetch_hold_buf u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (buf_load_s),
      .clear_i (buf_clear_s),
      .data_i  (imem_data),
      .data_o  (buf_data_s),
      .full_o  (buf_full_s)
   );

   // State, PC, saved redirect target and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         err_q   <= err_d;
      end
   end

   // Next-state, next-PC and buffer control.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      err_d       = err_q;
      buf_load_s  = 1'b0;
      buf_clear_s = 1'b0;
      case (state_q)
         ST_FETCH, ST_WAIT: begin
            // A misaligned PC never issues a read, so a redirect there is immediate.
            if (redirect) begin
               if (imem_done || (state_q == ST_FETCH && misalign_s)) begin
                  pc_d    = redirect_pc;
                  state_d = ST_FETCH;
               end else begin
                  tgt_d   = redirect_pc;
                  state_d = ST_SQUASH;
               end
            end else if (state_q == ST_FETCH && misalign_s) begin
               err_d   = 1'b1;
               state_d = ST_HALTED;
            end else if (imem_done) begin
               if (imem_err) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
               end else if (stall) begin
                  buf_load_s = 1'b1;
                  state_d    = ST_HOLD;
               end else if (is_halt(imem_data)) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_inc_s;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d        = redirect_pc;
               buf_clear_s = 1'b1;
               state_d     = ST_FETCH;
            end else if (!stall) begin
               buf_clear_s = 1'b1;
               if (is_halt(buf_data_s)) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_inc_s;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_SQUASH: begin
            if (imem_done) begin
               pc_d    = redirect ? redirect_pc : tgt_q;
               state_d = ST_FETCH;
            end else if (redirect) begin
               tgt_d = redirect_pc;
            end else begin
               state_d = ST_SQUASH;
            end
         end
         ST_HALTED: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Memory request and IF/D outputs; everything is forced idle while rst is high.
   always_comb begin
      imem_rd     = 1'b0;
      instr_out   = NOP_INSTR;
      valid       = 1'b0;
      fetch_stall = 1'b0;
      halted      = 1'b0;
      if (rst) begin
         imem_rd = 1'b0;
      end else begin
         case (state_q)
            ST_FETCH, ST_WAIT: begin
               if (state_q == ST_FETCH && misalign_s) begin
                  imem_rd = 1'b0;
               end else begin
                  imem_rd     = 1'b1;
                  fetch_stall = !imem_done;
                  if (imem_done && !imem_err && !redirect) begin
                     instr_out = imem_data;
                     valid     = 1'b1;
                  end else begin
                     valid = 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (!redirect) begin
                  instr_out = buf_data_s;
                  valid     = buf_full_s;
               end else begin
                  valid = 1'b0;
               end
            end
            ST_SQUASH: begin
               imem_rd     = 1'b1;
               fetch_stall = !imem_done;
            end
            ST_HALTED: begin
               halted = 1'b1;
            end
            default: begin
               imem_rd = 1'b0;
            end
         endcase
      end
   end

   assign imem_addr    = pc_q;
   assign pc_add_2_out = pc_inc_s;
   assign err          = err_q;

endmodule
